// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order posted-write buffer between the core data port and data memory
// Accepts stores into a circular FIFO, drains them in order and forwards pending data to loads.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [31:0]                DataAdr,
  input  logic [31:0]                WriteData,
  input  logic [3:0]                 WriteMask,
  output logic                       StoreStall,
  input  logic [31:0]                LdAdr,
  output logic                       FwdHit,
  output logic                       FwdPartial,
  output logic [31:0]                FwdData,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_be,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [3:0]       mask_q [DEPTH];
  logic [3:0]       mask_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push, pop;
  logic             fwd_found;
  logic [PTR_W-1:0] fwd_idx;
  logic [PTR_W-1:0] scan_idx;
  logic             unused_ld;

  assign StoreStall = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign mem_valid  = !empty;
  assign mem_addr   = addr_q[head_q];
  assign mem_wdata  = data_q[head_q];
  assign mem_be     = mask_q[head_q];

  assign push = MemWrite && !StoreStall;
  assign pop  = mem_valid && mem_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
      mask_d[i] = mask_q[i];
    end
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // Push and pop never target the same slot: push needs not-full, pop needs not-empty.
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push) begin
      addr_d[tail_q]  = DataAdr;
      data_d[tail_q]  = WriteData;
      mask_d[tail_q]  = WriteMask;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so the last match left standing is the youngest store.
  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (valid_q[scan_idx] && (addr_q[scan_idx][31:2] == LdAdr[31:2])) begin
        fwd_found = 1'b1;
        fwd_idx   = scan_idx;
      end
    end
  end

  assign FwdHit     = fwd_found && (mask_q[fwd_idx] == 4'hF);
  assign FwdPartial = fwd_found && (mask_q[fwd_idx] != 4'hF);
  assign FwdData    = fwd_found ? data_q[fwd_idx] : 32'h0;
  assign unused_ld  = ^LdAdr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
        mask_q[i] <= mask_d[i];
      end
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer directly downstream of the RV32 pipelined core's data-memory port. It captures each store the core issues on MemWrite/DataAdr/WriteData into a small in-order FIFO. It drains those stores to the data memory over a valid/ready handshake and forwards buffered data to loads that hit a pending store. Stores then retire from the Memory stage without waiting on memory latency.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; buffer is cleared while 0
- MemWrite  in  1  core store request this cycle
- DataAdr  in  32  store address (byte address)
- WriteData  in  32  store data, already lane-aligned
- WriteMask  in  4  byte enables for WriteData; bit i covers byte i
- StoreStall  out  1  buffer full; core must hold the store and freeze the pipeline
- LdAdr  in  32  address of the load currently in the Memory stage
- FwdHit  out  1  load fully satisfied from the buffer
- FwdPartial  out  1  load overlaps a pending store that cannot be fully forwarded; core must stall the load
- FwdData  out  32  forwarded word; valid when FwdHit=1
- mem_valid  out  1  head entry presented to memory
- mem_ready  in  1  memory accepts the head entry
- mem_addr  out  32  head entry address
- mem_wdata  out  32  head entry data
- mem_be  out  4  head entry byte enables
- empty  out  1  no pending stores
- count  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Storage is circular: DEPTH entries of {addr, data, mask, valid}, plus head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and a count register.
- Push = MemWrite && !StoreStall. The push writes {DataAdr, WriteData, WriteMask} at tail, sets its valid bit and increments tail.
- Pop = mem_valid && mem_ready. The pop clears the head valid bit and increments head.
- count update:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged
- StoreStall = (count == DEPTH). The stall is driven only from registered count. A pop in the same cycle does not admit a push; the store is accepted on the following cycle.
- MemWrite while StoreStall=1 is ignored. The core is required to hold the request.
- A push with WriteMask=0 is still accepted and drained. Memory then performs no byte writes.
- mem_valid = !empty. mem_addr, mem_wdata and mem_be are driven straight from the head entry's registers, with no combinational path from core inputs.
- While mem_valid=1 and mem_ready=0, all mem_* outputs stay stable.
- Drain order is strictly the order of acceptance.
- Forwarding is combinational over stored valid entries only:
  - An entry matches when entry.addr[31:2] == LdAdr[31:2].
  - Among matches, the youngest (closest to tail) wins.
  - If the winner's mask is 4'hF: FwdHit=1, FwdData=winner.data, FwdPartial=0.
  - If the winner's mask is not 4'hF: FwdPartial=1, FwdHit=0.
  - With no match: FwdHit=0, FwdPartial=0, FwdData=0.
- The store being pushed in the current cycle is not visible to forwarding until the next cycle.
- An entry being popped in the current cycle is still visible to forwarding.

## Timing
- Reset values (asynchronous, while reset=0):
  - head=0, tail=0, count=0, all valid bits and entry fields 0
  - mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0
  - empty=1, StoreStall=0, FwdHit=0, FwdPartial=0, FwdData=0
- Reset asserted mid-drain discards all entries immediately. mem_valid drops asynchronously.
- Push-to-mem_valid latency is 1 cycle: a store accepted at edge N appears at mem_* after edge N.
- With mem_ready held at 1, throughput is one store per cycle. count stays at 1 under continuous push and pop.
- Full to not-full: a pop at edge N clears StoreStall after edge N.

## Test plan
- Reset then idle: after reset=1, outputs match the reset values; with mem_ready=1 and no MemWrite for 10 cycles, mem_valid stays 0.
- Single store: MemWrite with DataAdr=100, WriteData=25, mask F and mem_ready=1 → next cycle mem_valid=1, mem_addr=100, mem_wdata=25, mem_be=F; one cycle later empty=1.
- Fill and backpressure: mem_ready=0; push 5 stores to addresses 96,100,104,108,112 → StoreStall=1 after the 4th, the 5th is held; then raise mem_ready → drain order 96,100,104,108, then 112 accepted and drained last.
- Simultaneous push and pop with count=2 → count stays 2 and pointers wrap correctly across 3×DEPTH operations.
- Forwarding with mem_ready=0:
  - Push (100, 25, F) then (100, 77, F); LdAdr=100 → FwdHit=1, FwdData=77.
  - LdAdr=102 → same result (word match).
  - LdAdr=96 → FwdHit=0, FwdPartial=0.
  - Push (104, 0x11, 4'b0001); LdAdr=104 → FwdPartial=1.
- Reset mid-operation: 3 entries pending and mem_valid=1; pulse reset low between edges → mem_valid=0 and count=0 at once, and no stale entry is driven after release.
